// File: rtl/ipf_pkg.sv
// Shared types and default geometry for the IPF result buffer.
package ipf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ipf_state_e;

  localparam int unsigned IPF_LANES  = 128;
  localparam int unsigned IPF_LANE_W = 9;
  localparam int unsigned IPF_DEPTH  = 128;

endpackage

// File: rtl/ipf_lane_ser.sv
// Word-to-lane serialiser: steps through the lanes of the presented word under
// a valid/ready handshake; the caller advances to the next word on word_done.
module ipf_lane_ser
  import ipf_pkg::*;
#(
  parameter int unsigned LANES  = IPF_LANES,
  parameter int unsigned LANE_W = IPF_LANE_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      start,
  input  logic                      last_word,
  input  logic [LANES*LANE_W-1:0]   word,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [LANE_W-1:0]         out_data,
  output logic                      out_last,
  output logic                      word_done
);

  localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;

  logic [LW-1:0] lane_r;
  logic          valid_r;
  logic          last_lane_s;
  logic          accept_s;

  assign last_lane_s = (lane_r == LW'(LANES - 1));
  assign accept_s    = valid_r && out_ready;

  // Lane index and valid flag; valid drops only after the final lane of the final word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= 1'b0;
      lane_r  <= '0;
    end else if (clr) begin
      valid_r <= 1'b0;
      lane_r  <= '0;
    end else if (start) begin
      valid_r <= 1'b1;
      lane_r  <= '0;
    end else if (accept_s) begin
      if (last_lane_s) begin
        lane_r <= '0;
        if (last_word) begin
          valid_r <= 1'b0;
        end else begin
          valid_r <= 1'b1;
        end
      end else begin
        lane_r <= lane_r + LW'(1);
      end
    end else begin
      lane_r <= lane_r;
    end
  end

  // Data is gated so that reset and idle both present zero on the lane bus.
  assign out_valid = valid_r;
  assign out_data  = valid_r ? word[lane_r*LANE_W +: LANE_W] : '0;
  assign out_last  = valid_r && last_lane_s && last_word;
  assign word_done = accept_s && last_lane_s;

endmodule

// File: rtl/ipf_res_buf.sv
// Result buffer: captures engine result words until finish, then drains them
// lane by lane. Optional output comparator enabled by `define IPF_RES_CMP_EN.
module ipf_res_buf
  import ipf_pkg::*;
#(
  parameter  int unsigned LANES  = IPF_LANES,
  parameter  int unsigned LANE_W = IPF_LANE_W,
  parameter  int unsigned DEPTH  = IPF_DEPTH,
  localparam int unsigned RW     = LANES * LANE_W,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              res_valid,
  input  logic [RW-1:0]     res,
  input  logic              finish,
  input  logic              out_ready,
`ifdef IPF_RES_CMP_EN
  input  logic [LANE_W-1:0] exp_data,
  output logic              mismatch,
  output logic [15:0]       err_cnt,
`endif
  output logic              out_valid,
  output logic [LANE_W-1:0] out_data,
  output logic              out_last,
  output logic [AW:0]       count,
  output logic              overflow,
  output logic              busy
);

  localparam int unsigned CW = AW + 1;

  ipf_state_e    state_r, state_s;
  logic [RW-1:0] mem [DEPTH];
  logic [CW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          overflow_r;
  logic          full_s, cap_s, drop_s, start_s, word_done_s, last_word_s;

  // wr_ptr never wraps, so it doubles as the full indicator while filling.
  assign full_s      = (wr_ptr_r == CW'(DEPTH));
  assign cap_s       = res_valid && !full_s && (state_r == ST_IDLE || state_r == ST_FILL);
  assign drop_s      = res_valid && !cap_s;
  assign last_word_s = (count_r == CW'(1));

  // Next-state decode; a word captured alongside finish is drained with the rest.
  always_comb begin
    state_s = state_r;
    start_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (res_valid && finish) begin
          state_s = ST_DRAIN;
          start_s = 1'b1;
        end else if (res_valid) begin
          state_s = ST_FILL;
        end else if (finish) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (finish && (count_r != '0 || cap_s)) begin
          state_s = ST_DRAIN;
          start_s = 1'b1;
        end else if (finish) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_FILL;
        end
      end
      ST_DRAIN: begin
        if (word_done_s && out_last) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DONE:  state_s = ST_DONE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Control state, pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
    end else if (clr) begin
      state_r    <= ST_IDLE;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      state_r <= state_s;
      if (cap_s) begin
        wr_ptr_r <= wr_ptr_r + CW'(1);
        count_r  <= count_r + CW'(1);
      end else if (word_done_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
        count_r  <= count_r - CW'(1);
      end else begin
        count_r <= count_r;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  // Word storage is left unreset; only written entries are ever read.
  always_ff @(posedge clk) begin
    if (cap_s && !clr) begin
      mem[wr_ptr_r[AW-1:0]] <= res;
    end
  end

  ipf_lane_ser #(
    .LANES  (LANES),
    .LANE_W (LANE_W)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .start     (start_s),
    .last_word (last_word_s),
    .word      (mem[rd_ptr_r]),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .word_done (word_done_s)
  );

  assign count    = count_r;
  assign overflow = overflow_r;
  assign busy     = (state_r == ST_FILL) || (state_r == ST_DRAIN);

`ifdef IPF_RES_CMP_EN
  logic        mismatch_r;
  logic [15:0] err_cnt_r;
  logic        bad_beat_s;

  assign bad_beat_s = out_valid && out_ready && (out_data != exp_data);

  // Per-beat compare against the expected lane; error count saturates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mismatch_r <= 1'b0;
      err_cnt_r  <= 16'h0000;
    end else if (clr) begin
      mismatch_r <= 1'b0;
      err_cnt_r  <= 16'h0000;
    end else begin
      mismatch_r <= bad_beat_s;
      if (bad_beat_s && err_cnt_r != 16'hFFFF) begin
        err_cnt_r <= err_cnt_r + 16'h0001;
      end else begin
        err_cnt_r <= err_cnt_r;
      end
    end
  end

  assign mismatch = mismatch_r;
  assign err_cnt  = err_cnt_r;
`endif

endmodule
